// File: rtl/stage_sequencer.sv
// Stage controller for the Lua core: walks each instruction through FETCH/DECODE/EXEC/WB,
// owns the program counter, and halts the core on a fetch timeout or an illegal opcode.
module stage_sequencer #(
  parameter int PC_WIDTH  = 32,
  parameter int TIMEOUT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                stop,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic [31:0]         instr,
  output logic                en_decode,
  output logic                en_ex,
  output logic                en_wb,
  input  logic                ex_busy,
  input  logic                ex_illegal,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                running,
  output logic                fault,
  output logic [1:0]          fault_code,
  output logic [31:0]         retired,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Last count value before the timeout fires: the next un-acked cycle would hit all-ones.
  localparam logic [TIMEOUT_W-1:0] TO_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  state_t               state;
  logic                 stop_pend;
  logic [TIMEOUT_W-1:0] to_cnt;
  logic                 is_running;

  assign is_running = (state != S_IDLE) && (state != S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      instr      <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
      retired    <= '0;
      stop_pend  <= 1'b0;
      to_cnt     <= '0;
    end else begin
      if (is_running && stop) stop_pend <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc    <= start_pc;
            state <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (imem_ack) begin
            instr  <= imem_data;
            to_cnt <= '0;
            state  <= S_DECODE;
          end else if (to_cnt == TO_LAST) begin
            to_cnt     <= '0;
            fault      <= 1'b1;
            fault_code <= 2'b01;
            stop_pend  <= 1'b0;
            state      <= S_HALT;
          end else begin
            to_cnt <= to_cnt + TIMEOUT_W'(1);
          end
        end
        S_DECODE: state <= S_EXEC;
        S_EXEC: begin
          if (ex_illegal) begin
            fault      <= 1'b1;
            fault_code <= 2'b10;
            stop_pend  <= 1'b0;
            state      <= S_HALT;
          end else if (!ex_busy) begin
            state <= S_WB;
          end
        end
        S_WB: begin
          retired   <= retired + 32'd1;
          pc        <= branch_taken ? branch_target : pc + PC_WIDTH'(1);
          stop_pend <= 1'b0;
          state     <= (stop_pend || stop) ? S_IDLE : S_FETCH;
        end
        S_HALT: begin
          // pc stays at the faulting instruction until a restart reloads it.
          if (start) begin
            fault      <= 1'b0;
            fault_code <= 2'b00;
            pc         <= start_pc;
            state      <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake: imem_req is a level held through FETCH; a fetch completes on the
  // first cycle imem_ack is seen with imem_req high. Strobes decode from state only.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign en_decode = (state == S_DECODE);
  assign en_ex     = (state == S_EXEC);
  assign en_wb     = (state == S_WB);
  assign running   = is_running;
  assign state_dbg = state;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: hand sequences plus a vector table; a queue tracks
// which instruction word each WB must carry.
module tb_stage_sequencer;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                         ST_EXEC = 3'd3, ST_WB = 3'd4, ST_HALT = 3'd5;

  logic        clk = 1'b0;
  logic        reset, start, stop, imem_ack, ex_busy, ex_illegal, branch_taken;
  logic [31:0] start_pc, imem_data, branch_target;
  logic        imem_req, en_decode, en_ex, en_wb, running, fault;
  logic [31:0] imem_addr, instr, pc, retired;
  logic [1:0]  fault_code;
  logic [2:0]  state_dbg;

  stage_sequencer #(.PC_WIDTH(32), .TIMEOUT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .start_pc(start_pc), .stop(stop),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_data(imem_data), .instr(instr), .en_decode(en_decode), .en_ex(en_ex),
    .en_wb(en_wb), .ex_busy(ex_busy), .ex_illegal(ex_illegal),
    .branch_taken(branch_taken), .branch_target(branch_target), .pc(pc),
    .running(running), .fault(fault), .fault_code(fault_code), .retired(retired),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_retired;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // scoreboard: every WB must present the next queued instruction word
  always @(negedge clk) begin
    if (!reset && en_wb) begin
      if (exp_q.size() == 0) check("wb_unexpected", 32'd1, 32'd0);
      else check("wb_instr", instr, exp_q.pop_front());
    end
  end

  // driver: from a FETCH cycle, run one instruction through to the cycle after WB
  task automatic run_instr(input logic [31:0] data, input int busy, input logic br,
                           input logic [31:0] tgt, input logic stp);
    int ex_cycles;
    imem_ack = 1'b1; imem_data = data; exp_q.push_back(data);
    step();
    imem_ack = 1'b0; imem_data = $urandom;
    check("en_decode", {31'd0, en_decode}, 32'd1);
    start = 1'b1; start_pc = 32'hBAD0;           // must be ignored while running
    step();
    start = 1'b0;
    check("decode_one_cycle", {31'd0, en_decode}, 32'd0);
    ex_cycles = 0;
    for (int i = 0; i <= busy; i++) begin
      ex_busy = (i < busy);
      stop    = stp && (i == busy);
      if (en_ex) ex_cycles++;
      step();
    end
    ex_busy = 1'b0; stop = 1'b0;
    check("ex_cycles", ex_cycles, busy + 1);
    check("en_wb", {31'd0, en_wb}, 32'd1);
    branch_taken = br; branch_target = tgt;
    step();
    branch_taken = 1'b0; branch_target = $urandom;
    exp_retired++;
  endtask

  typedef struct {
    logic        do_start;
    logic [31:0] spc;
    int          busy;
    logic        br;
    logic [31:0] tgt;
    logic        stp;
    logic [31:0] exp_pc;
    logic        exp_run;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int fetch_cycles, ex_cycles;
    reset = 1'b1; start = 0; stop = 0; imem_ack = 0; ex_busy = 0; ex_illegal = 0;
    branch_taken = 0; start_pc = '0; imem_data = '0; branch_target = '0;
    exp_retired = 0;

    vecs[0] = '{1'b0, 32'h0,        0, 1'b0, 32'h0,        1'b0, 32'h12,       1'b1};
    vecs[1] = '{1'b0, 32'h0,        2, 1'b1, 32'h40,       1'b0, 32'h40,       1'b1};
    vecs[2] = '{1'b0, 32'h0,        1, 1'b0, 32'h0,        1'b1, 32'h41,       1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFFF, 0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
    vecs[4] = '{1'b0, 32'h0,        3, 1'b1, 32'h7FFFFFFE, 1'b1, 32'h7FFFFFFE, 1'b0};
    vecs[5] = '{1'b1, 32'h20,       0, 1'b0, 32'h0,        1'b0, 32'h21,       1'b1};

    step(); step();
    reset = 1'b0;
    check("rst_state",   {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("rst_pc",      pc, 32'h0);
    check("rst_instr",   instr, 32'h0);
    check("rst_outs",    {26'd0, imem_req, en_decode, en_ex, en_wb, running, fault}, 32'h0);
    check("rst_code",    {30'd0, fault_code}, 32'h0);
    check("rst_retired", retired, 32'h0);

    // basic 4-cycle instruction from 0x10
    start = 1'b1; start_pc = 32'h10;
    step();
    start = 1'b0;
    check("t1_fetch_addr", imem_addr, 32'h10);
    check("t1_imem_req", {31'd0, imem_req}, 32'd1);
    run_instr($urandom, 0, 1'b0, 32'h0, 1'b0);
    check("t1_pc", pc, 32'h11);
    check("t1_retired", retired, 32'd1);
    check("t1_state", {29'd0, state_dbg}, {29'd0, ST_FETCH});

    // table: branches, busy stalls, stop returns, pc wrap, start-beats-stop in IDLE
    for (int v = 0; v < 6; v++) begin
      if (vecs[v].do_start) begin
        check("v_idle_before_start", {31'd0, running}, 32'd0);
        start = 1'b1; stop = 1'b1; start_pc = vecs[v].spc;
        step();
        start = 1'b0; stop = 1'b0;
        check("v_start_addr", imem_addr, vecs[v].spc);
      end
      run_instr($urandom, vecs[v].busy, vecs[v].br, vecs[v].tgt, vecs[v].stp);
      check("v_pc", pc, vecs[v].exp_pc);
      check("v_running", {31'd0, running}, {31'd0, vecs[v].exp_run});
      check("v_imem_req", {31'd0, imem_req}, {31'd0, vecs[v].exp_run});
      check("v_retired", retired, exp_retired);
      if (vecs[v].exp_run) check("v_next_addr", imem_addr, vecs[v].exp_pc);
    end

    // fetch timeout: 15 un-acked FETCH cycles then HALT
    fetch_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!imem_req) break;
      fetch_cycles++;
      step();
    end
    check("to_cycles", fetch_cycles, 32'd15);
    check("to_state", {29'd0, state_dbg}, {29'd0, ST_HALT});
    check("to_fault", {31'd0, fault}, 32'd1);
    check("to_code", {30'd0, fault_code}, 32'd1);
    check("to_pc", pc, 32'h21);
    check("to_running", {31'd0, running}, 32'd0);

    start = 1'b1; start_pc = 32'h0;
    step();
    start = 1'b0;
    check("restart_fault", {31'd0, fault}, 32'd0);
    check("restart_code", {30'd0, fault_code}, 32'd0);
    check("restart_req", {31'd0, imem_req}, 32'd1);
    check("restart_addr", imem_addr, 32'h0);

    // ack in the 15th FETCH cycle wins over the timeout
    for (int i = 0; i < 14; i++) step();
    imem_ack = 1'b1; imem_data = 32'hC0DE_0001;
    step();
    imem_ack = 1'b0;
    check("late_ack_decode", {29'd0, state_dbg}, {29'd0, ST_DECODE});
    check("late_ack_instr", instr, 32'hC0DE_0001);
    step();

    // busy for 3 cycles, then illegal with busy -> HALT code 10
    ex_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      ex_busy = 1'b1; ex_illegal = (i == 3);
      if (en_ex) ex_cycles++;
      step();
    end
    ex_busy = 1'b0; ex_illegal = 1'b0;
    check("ill_ex_cycles", ex_cycles, 32'd4);
    check("ill_state", {29'd0, state_dbg}, {29'd0, ST_HALT});
    check("ill_code", {30'd0, fault_code}, 32'd2);
    check("ill_fault", {31'd0, fault}, 32'd1);
    check("ill_pc", pc, 32'h0);

    // stop in HALT is ignored: next instruction continues to FETCH
    stop = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b1; start_pc = 32'h55;
    step();
    start = 1'b0;
    run_instr($urandom, 0, 1'b0, 32'h0, 1'b0);
    check("halt_stop_ignored", {31'd0, running}, 32'd1);
    check("halt_stop_pc", pc, 32'h56);

    // reset mid-FETCH, late ack afterwards must be ignored
    step();
    reset = 1'b1;
    step();
    reset = 1'b0; imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    check("rst2_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
    check("rst2_instr", instr, 32'h0);
    check("rst2_pc", pc, 32'h0);
    check("rst2_outs", {26'd0, imem_req, en_decode, en_ex, en_wb, running, fault}, 32'h0);
    check("rst2_retired", retired, 32'h0);
    check("sb_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
